tablet_fill_ctrl: RTL and testbench

//  Sequencer for the tablet filling machine. Holds the operator-set targets:

---
 rtl/tablet_fill_ctrl_if.sv | 31 +++
 rtl/tablet_fill_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_tablet_fill_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tablet_fill_ctrl_if.sv
// Operator keys, tablet sensor and display/actuator outputs of the tablet fill controller.
// slave  : controller side (keys and sensor in, counts/status out).
// master : panel/bench side (drives keys and sensor, observes outputs).
interface tablet_fill_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             key_set_i;
  logic             key_start_i;
  logic             key_left_i;
  logic             key_inc_i;
  logic             tablet_in_i;
  logic [CNT_W-1:0] tablet_cnt_o;
  logic [CNT_W-1:0] bottle_cnt_o;
  logic [2:0]       pos_o;
  logic             set_mod_o;
  logic             motor_on_o;
  logic             valve_open_o;
  logic             done_o;

  modport slave (
    input  key_set_i, key_start_i, key_left_i, key_inc_i, tablet_in_i,
    output tablet_cnt_o, bottle_cnt_o, pos_o, set_mod_o,
           motor_on_o, valve_open_o, done_o
  );

  modport master (
    output key_set_i, key_start_i, key_left_i, key_inc_i, tablet_in_i,
    input  tablet_cnt_o, bottle_cnt_o, pos_o, set_mod_o,
           motor_on_o, valve_open_o, done_o
  );
endinterface

// File: rtl/tablet_fill_ctrl.sv
// Tablet filling sequencer: BCD targets, tablet/bottle counting, bottle-change dwell.
// Latency: outputs register 1 clk after a key; tablet_in edge reaches the counts in 3 clk.
// Backpressure: none; keys outside their listed states and sensor pulses outside RUN are dropped.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       key_set/start/left/inc pulses, raw tablet_in,
//                     tablet_cnt/bottle_cnt/pos/set_mod/motor_on/valve_open/done outputs
module tablet_fill_ctrl #(
  parameter int CNT_W   = 32,
  parameter int GAP_CYC = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  tablet_fill_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SET    = 3'd1,
    ST_RUN    = 3'd2,
    ST_CHANGE = 3'd3,
    ST_PAUSE  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int             GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  // Three BCD digits packed as {hundreds, tens, units}.
  function automatic logic [9:0] bcd3_to_bin(input logic [11:0] d);
    return 10'(d[11:8]) * 10'd100 + 10'(d[7:4]) * 10'd10 + 10'(d[3:0]);
  endfunction

  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // Cursor walks the six editable digits; 3 and 7 are gaps between the two fields.
  function automatic logic [2:0] pos_next(input logic [2:0] p);
    logic [2:0] n;
    case (p)
      3'd0:    n = 3'd1;
      3'd1:    n = 3'd2;
      3'd2:    n = 3'd4;
      3'd4:    n = 3'd5;
      3'd5:    n = 3'd6;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       pos_q, pos_d;
  logic [11:0]      tgt_tab_q, tgt_tab_d;
  logic [11:0]      tgt_bot_q, tgt_bot_d;
  logic [9:0]       tab_cnt_q, tab_cnt_d;
  logic [9:0]       bot_cnt_q, bot_cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic             tin_meta_q, tin_sync_q, tin_prev_q;
  logic             tab_pulse;

  logic [CNT_W-1:0] tab_out_q, bot_out_q;
  logic             set_mod_q, motor_q, valve_q, done_q;

  logic [9:0]       tab_tgt_val, bot_tgt_val;
  logic [9:0]       tab_cnt_inc, bot_cnt_inc;
  logic             bottle_full, batch_full;

  assign tab_pulse   = tin_sync_q & ~tin_prev_q;
  assign tab_tgt_val = bcd3_to_bin(tgt_tab_q);
  assign bot_tgt_val = bcd3_to_bin(tgt_bot_q);
  assign tab_cnt_inc = tab_cnt_q + 10'd1;
  assign bot_cnt_inc = bot_cnt_q + 10'd1;
  assign bottle_full = (tab_cnt_inc == tab_tgt_val);
  assign batch_full  = bottle_full && (bot_cnt_inc == bot_tgt_val);

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    tgt_tab_d = tgt_tab_q;
    tgt_bot_d = tgt_bot_q;
    tab_cnt_d = tab_cnt_q;
    bot_cnt_d = bot_cnt_q;
    gap_d     = gap_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.key_set_i) begin
          state_d = ST_SET;
          pos_d   = 3'd0;
        end else if (bus.key_start_i && tab_tgt_val != 10'd0 && bot_tgt_val != 10'd0) begin
          state_d   = ST_RUN;
          tab_cnt_d = '0;
          bot_cnt_d = '0;
        end
      end

      ST_SET: begin
        if (bus.key_set_i) begin
          state_d = ST_IDLE;
        end else if (bus.key_left_i) begin
          pos_d = pos_next(pos_q);
        end else if (bus.key_inc_i) begin
          case (pos_q)
            3'd0:    tgt_tab_d[3:0]  = digit_inc(tgt_tab_q[3:0]);
            3'd1:    tgt_tab_d[7:4]  = digit_inc(tgt_tab_q[7:4]);
            3'd2:    tgt_tab_d[11:8] = digit_inc(tgt_tab_q[11:8]);
            3'd4:    tgt_bot_d[3:0]  = digit_inc(tgt_bot_q[3:0]);
            3'd5:    tgt_bot_d[7:4]  = digit_inc(tgt_bot_q[7:4]);
            3'd6:    tgt_bot_d[11:8] = digit_inc(tgt_bot_q[11:8]);
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        if (tab_pulse) begin
          if (bottle_full) begin
            tab_cnt_d = '0;
            bot_cnt_d = bot_cnt_inc;
          end else begin
            tab_cnt_d = tab_cnt_inc;
          end
        end
        // The pulse is counted first; a completed batch outranks a pause
        // request so the machine never sits paused with nothing left to fill.
        if (tab_pulse && batch_full) begin
          state_d = ST_DONE;
        end else if (bus.key_start_i) begin
          state_d = ST_PAUSE;
        end else if (tab_pulse && bottle_full) begin
          state_d = ST_CHANGE;
          gap_d   = '0;
        end
      end

      ST_CHANGE: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_RUN;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      ST_PAUSE: begin
        if (bus.key_set_i) begin
          state_d   = ST_IDLE;
          tab_cnt_d = '0;
          bot_cnt_d = '0;
        end else if (bus.key_start_i) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        if (bus.key_set_i) begin
          state_d = ST_SET;
        end else if (bus.key_start_i) begin
          state_d   = ST_RUN;
          tab_cnt_d = '0;
          bot_cnt_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and display outputs are both taken from next-state values so
  // every output lands on the same edge as the state change that causes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pos_q      <= '0;
      tgt_tab_q  <= '0;
      tgt_bot_q  <= '0;
      tab_cnt_q  <= '0;
      bot_cnt_q  <= '0;
      gap_q      <= '0;
      tin_meta_q <= 1'b0;
      tin_sync_q <= 1'b0;
      tin_prev_q <= 1'b0;
      tab_out_q  <= '0;
      bot_out_q  <= '0;
      set_mod_q  <= 1'b0;
      motor_q    <= 1'b0;
      valve_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      tgt_tab_q  <= tgt_tab_d;
      tgt_bot_q  <= tgt_bot_d;
      tab_cnt_q  <= tab_cnt_d;
      bot_cnt_q  <= bot_cnt_d;
      gap_q      <= gap_d;
      tin_meta_q <= bus.tablet_in_i;
      tin_sync_q <= tin_meta_q;
      tin_prev_q <= tin_sync_q;
      tab_out_q  <= CNT_W'((state_d == ST_SET) ? bcd3_to_bin(tgt_tab_d) : tab_cnt_d);
      bot_out_q  <= CNT_W'((state_d == ST_SET) ? bcd3_to_bin(tgt_bot_d) : bot_cnt_d);
      set_mod_q  <= (state_d == ST_SET);
      motor_q    <= (state_d == ST_RUN);
      valve_q    <= (state_d == ST_RUN);
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign bus.tablet_cnt_o = tab_out_q;
  assign bus.bottle_cnt_o = bot_out_q;
  assign bus.pos_o        = pos_q;
  assign bus.set_mod_o    = set_mod_q;
  assign bus.motor_on_o   = motor_q;
  assign bus.valve_open_o = valve_q;
  assign bus.done_o       = done_q;

endmodule

// File: tb/tb_tablet_fill_ctrl.sv
// Directed bench for tablet_fill_ctrl with hand-computed expected values.
module tb_tablet_fill_ctrl;
  localparam int CNT_W   = 32;
  localparam int GAP_CYC = 8;

  localparam int K_SET   = 0;
  localparam int K_START = 1;
  localparam int K_LEFT  = 2;
  localparam int K_INC   = 3;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  tablet_fill_ctrl_if #(.CNT_W(CNT_W)) bus ();

  tablet_fill_ctrl #(.CNT_W(CNT_W), .GAP_CYC(GAP_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int key, input int n);
    for (int i = 0; i < n; i++) begin
      case (key)
        K_SET:   bus.key_set_i   = 1'b1;
        K_START: bus.key_start_i = 1'b1;
        K_LEFT:  bus.key_left_i  = 1'b1;
        default: bus.key_inc_i   = 1'b1;
      endcase
      tick();
      bus.key_set_i   = 1'b0;
      bus.key_start_i = 1'b0;
      bus.key_left_i  = 1'b0;
      bus.key_inc_i   = 1'b0;
    end
  endtask

  // Returns right after the edge that updates the counts.
  task automatic tab_rise();
    bus.tablet_in_i = 1'b1;
    tick();
    tick();
    bus.tablet_in_i = 1'b0;
    tick();
  endtask

  task automatic tab_one();
    tab_rise();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tab"},   bus.tablet_cnt_o, 0);
    check({tag, "_bot"},   bus.bottle_cnt_o, 0);
    check({tag, "_pos"},   32'(bus.pos_o), 0);
    check({tag, "_set"},   32'(bus.set_mod_o), 0);
    check({tag, "_motor"}, 32'(bus.motor_on_o), 0);
    check({tag, "_valve"}, 32'(bus.valve_open_o), 0);
    check({tag, "_done"},  32'(bus.done_o), 0);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.key_set_i   = 1'b0;
    bus.key_start_i = 1'b0;
    bus.key_left_i  = 1'b0;
    bus.key_inc_i   = 1'b0;
    bus.tablet_in_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_all_zero("reset");

    // Target editing
    press(K_SET, 1);
    check("set_enter", 32'(bus.set_mod_o), 1);
    check("set_pos0", 32'(bus.pos_o), 0);
    press(K_LEFT, 3);
    check("left3_pos", 32'(bus.pos_o), 4);
    press(K_INC, 2);
    check("bot_tgt2", bus.bottle_cnt_o, 2);
    press(K_LEFT, 3);
    check("left_wrap_pos", 32'(bus.pos_o), 0);
    press(K_INC, 10);
    check("units_wrap", bus.tablet_cnt_o, 0);
    press(K_INC, 1);
    check("tab_tgt1", bus.tablet_cnt_o, 1);
    press(K_INC, 2);
    check("tab_tgt3", bus.tablet_cnt_o, 3);
    press(K_LEFT, 2);
    check("pos_hund", 32'(bus.pos_o), 2);
    press(K_INC, 1);
    check("tab_tgt103", bus.tablet_cnt_o, 103);
    press(K_INC, 9);
    check("hund_wrap", bus.tablet_cnt_o, 3);
    press(K_LEFT, 1);
    check("skip3_pos", 32'(bus.pos_o), 4);
    press(K_SET, 1);
    check("set_leave", 32'(bus.set_mod_o), 0);
    check("pos_hold", 32'(bus.pos_o), 4);
    check("idle_tab", bus.tablet_cnt_o, 0);

    // Full batch 3 tablets x 2 bottles with a bottle change
    press(K_START, 1);
    check("run_motor", 32'(bus.motor_on_o), 1);
    check("run_valve", 32'(bus.valve_open_o), 1);
    tab_one();
    tab_one();
    check("tab_cnt2", bus.tablet_cnt_o, 2);
    tab_rise();
    check("b1_bot", bus.bottle_cnt_o, 1);
    check("b1_tab", bus.tablet_cnt_o, 0);
    check("chg_motor", 32'(bus.motor_on_o), 0);
    check("chg_valve", 32'(bus.valve_open_o), 0);
    tick();
    bus.tablet_in_i = 1'b1;
    tick();
    tick();
    bus.tablet_in_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("chg_last_motor", 32'(bus.motor_on_o), 0);
    check("chg_pulse_ign", bus.tablet_cnt_o, 0);
    tick();
    check("chg_end_motor", 32'(bus.motor_on_o), 1);
    check("chg_end_tab", bus.tablet_cnt_o, 0);
    tab_one();
    tab_one();
    tab_rise();
    check("done_flag", 32'(bus.done_o), 1);
    check("done_bot", bus.bottle_cnt_o, 2);
    check("done_tab", bus.tablet_cnt_o, 0);
    check("done_motor", 32'(bus.motor_on_o), 0);
    tick();

    // Zero tablet target blocks start
    press(K_SET, 1);
    check("done_to_set", 32'(bus.set_mod_o), 1);
    press(K_SET, 2);
    check("reset_pos0", 32'(bus.pos_o), 0);
    press(K_INC, 7);
    check("tab_tgt0", bus.tablet_cnt_o, 0);
    press(K_SET, 1);
    press(K_START, 1);
    check("zero_motor", 32'(bus.motor_on_o), 0);
    check("zero_set", 32'(bus.set_mod_o), 0);
    check("zero_done", 32'(bus.done_o), 0);

    // key_set outranks key_start
    bus.key_set_i   = 1'b1;
    bus.key_start_i = 1'b1;
    tick();
    bus.key_set_i   = 1'b0;
    bus.key_start_i = 1'b0;
    check("prio_set", 32'(bus.set_mod_o), 1);
    check("prio_motor", 32'(bus.motor_on_o), 0);
    press(K_INC, 7);
    check("tab_tgt7", bus.tablet_cnt_o, 7);
    press(K_SET, 1);
    press(K_START, 1);
    check("run2_motor", 32'(bus.motor_on_o), 1);
    check("run2_bot", bus.bottle_cnt_o, 0);

    // Pulse counted in the same cycle as the pause request
    tab_one();
    check("cnt1", bus.tablet_cnt_o, 1);
    bus.tablet_in_i = 1'b1;
    tick();
    tick();
    bus.key_start_i = 1'b1;
    bus.tablet_in_i = 1'b0;
    tick();
    bus.key_start_i = 1'b0;
    check("pause_cnt", bus.tablet_cnt_o, 2);
    check("pause_motor", 32'(bus.motor_on_o), 0);
    tick();
    tab_one();
    check("pause_ign", bus.tablet_cnt_o, 2);
    check("pause_valve", 32'(bus.valve_open_o), 0);
    press(K_START, 1);
    check("resume_motor", 32'(bus.motor_on_o), 1);
    check("resume_cnt", bus.tablet_cnt_o, 2);

    // Sensor edge handling
    bus.tablet_in_i = 1'b1;
    #2;
    bus.tablet_in_i = 1'b0;
    tick();
    tick();
    tick();
    check("subclk_glitch", bus.tablet_cnt_o, 2);
    bus.tablet_in_i = 1'b1;
    tick();
    bus.tablet_in_i = 1'b0;
    tick();
    tick();
    check("one_clk_pulse", bus.tablet_cnt_o, 3);
    tick();
    bus.tablet_in_i = 1'b1;
    tick();
    bus.tablet_in_i = 1'b0;
    tick();
    bus.tablet_in_i = 1'b1;
    tick();
    check("dbl_edge1", bus.tablet_cnt_o, 4);
    bus.tablet_in_i = 1'b0;
    tick();
    tick();
    check("dbl_edge2", bus.tablet_cnt_o, 5);

    // Reset in the middle of a run
    rst_n = 1'b0;
    tick();
    check_all_zero("rst_run");
    rst_n = 1'b1;
    tick();
    press(K_SET, 1);
    check("rst_set", 32'(bus.set_mod_o), 1);
    check("rst_tab_tgt", bus.tablet_cnt_o, 0);
    check("rst_bot_tgt", bus.bottle_cnt_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
